// File: rtl/menu_sequencer.sv
// Title-screen sequencer: attract loop, three-item menu, confirm pause and launch
// speed ramp ending in a one-cycle game-start pulse. All outputs are registered.
module menu_sequencer #(
    parameter int AUTO_JUMP    = 96,
    parameter int IDLE_TIMEOUT = 600,
    parameter int LAUNCH_HOLD  = 60,
    parameter int SPD_ATTRACT  = 2,
    parameter int SPD_MAX      = 8
) (
    input  logic        i_clk_pix,
    input  logic        i_rst_n,
    input  logic        i_frame,
    input  logic [5:0]  i_key,
    output logic        o_run,
    output logic [15:0] o_run_speed,
    output logic        o_jump,
    output logic [1:0]  o_cursor,
    output logic [2:0]  o_state,
    output logic        o_start
);

    typedef enum logic [2:0] {
        ATTRACT = 3'd0,
        SELECT  = 3'd1,
        CONFIRM = 3'd2,
        LAUNCH  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [9:0]  JUMP_LAST    = 10'(AUTO_JUMP - 1);
    localparam logic [9:0]  IDLE_LAST    = 10'(IDLE_TIMEOUT - 1);
    localparam logic [9:0]  HOLD_LAST    = 10'(LAUNCH_HOLD - 1);
    localparam logic [9:0]  CONFIRM_LAST = 10'd31;
    localparam logic [9:0]  RAMP_LAST    = 10'd7;
    localparam logic [15:0] SPEED_ATT    = 16'(SPD_ATTRACT);
    localparam logic [15:0] SPEED_TOP    = 16'(SPD_MAX);
    localparam logic [5:0]  WAKE_KEYS    = 6'b01_0011;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [5:0]  key_q, key_edge;
    logic        run_d, jump_d, start_d;
    logic [15:0] speed_d;
    logic [1:0]  cursor_d;

    assign key_edge = i_key & ~key_q;
    assign o_state  = state_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        run_d    = o_run;
        speed_d  = o_run_speed;
        cursor_d = o_cursor;
        jump_d   = 1'b0;
        start_d  = 1'b0;
        unique case (state_q)
            ATTRACT: begin
                if (i_frame) begin
                    if (cnt_q == JUMP_LAST) begin
                        jump_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
                if (|(key_edge & WAKE_KEYS)) begin
                    state_d  = SELECT;
                    run_d    = 1'b0;
                    cursor_d = 2'd0;
                    cnt_d    = '0;
                end
            end
            SELECT: begin
                // Key activity outranks the frame tick, so an edge on a timeout frame keeps the menu.
                if (key_edge[4]) begin
                    state_d = CONFIRM;
                    jump_d  = 1'b1;
                    cnt_d   = '0;
                end else if (key_edge[5]) begin
                    state_d = ATTRACT;
                    run_d   = 1'b1;
                    speed_d = SPEED_ATT;
                    cnt_d   = '0;
                end else if (|key_edge) begin
                    cnt_d = '0;
                    if (key_edge[0] && !key_edge[1])
                        cursor_d = (o_cursor == 2'd0) ? 2'd2 : o_cursor - 2'd1;
                    else if (key_edge[1] && !key_edge[0])
                        cursor_d = (o_cursor == 2'd2) ? 2'd0 : o_cursor + 2'd1;
                end else if (i_frame) begin
                    if (cnt_q == IDLE_LAST) begin
                        state_d = ATTRACT;
                        run_d   = 1'b1;
                        speed_d = SPEED_ATT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            CONFIRM: begin
                if (key_edge[5]) begin
                    state_d = SELECT;
                    cnt_d   = '0;
                end else if (i_frame) begin
                    if (cnt_q == CONFIRM_LAST) begin
                        state_d = LAUNCH;
                        run_d   = 1'b1;
                        speed_d = 16'd1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            LAUNCH: begin
                if (i_frame) begin
                    if (o_run_speed < SPEED_TOP) begin
                        if (cnt_q == RAMP_LAST) begin
                            speed_d = o_run_speed + 16'd1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = DONE;
                        start_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            DONE: begin
                run_d   = 1'b1;
                speed_d = SPEED_TOP;
            end
            default: state_d = ATTRACT;
        endcase
    end

    always_ff @(posedge i_clk_pix) begin
        // Sampled during reset too, so a key held through release yields no edge.
        key_q <= i_key;
        if (!i_rst_n) begin
            state_q     <= ATTRACT;
            cnt_q       <= '0;
            o_run       <= 1'b1;
            o_run_speed <= SPEED_ATT;
            o_jump      <= 1'b0;
            o_start     <= 1'b0;
            o_cursor    <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            o_run       <= run_d;
            o_run_speed <= speed_d;
            o_jump      <= jump_d;
            o_start     <= start_d;
            o_cursor    <= cursor_d;
        end
    end

endmodule

// File: tb/tb_menu_sequencer.sv
// Self-checking bench for menu_sequencer: directed scenarios plus randomized
// traffic compared against a frame-counting behavioural model.
module tb_menu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_frame = 1'b0;
    logic [5:0]  i_key = '0;
    logic        o_run, o_jump, o_start;
    logic [15:0] o_run_speed;
    logic [1:0]  o_cursor;
    logic [2:0]  o_state;

    int vectors = 0;
    int miscompares = 0;

    menu_sequencer dut (
        .i_clk_pix  (clk),
        .i_rst_n    (rst_n),
        .i_frame    (i_frame),
        .i_key      (i_key),
        .o_run      (o_run),
        .o_run_speed(o_run_speed),
        .o_jump     (o_jump),
        .o_cursor   (o_cursor),
        .o_state    (o_state),
        .o_start    (o_start)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0..4 = attract/select/confirm/launch/done.
    int         m_mode = 0, m_frames = 0, m_cursor = 0, m_speed = 2;
    bit         m_run = 1'b1, m_jump = 1'b0, m_start = 1'b0;
    logic [5:0] m_prev = '0;

    task automatic model_update(input bit rst, input bit frame, input logic [5:0] key);
        logic [5:0] edges;
        edges  = key & ~m_prev;
        m_prev = key;
        m_jump = 1'b0;
        m_start = 1'b0;
        if (!rst) begin
            m_mode = 0; m_frames = 0; m_cursor = 0; m_run = 1'b1; m_speed = 2;
            return;
        end
        case (m_mode)
            0: begin
                if (frame) begin
                    m_frames++;
                    if (m_frames % 96 == 0) begin m_jump = 1'b1; m_frames = 0; end
                end
                if ((edges & 6'h13) != 0) begin
                    m_mode = 1; m_run = 1'b0; m_cursor = 0; m_frames = 0;
                end
            end
            1: begin
                if (edges[4]) begin
                    m_mode = 2; m_jump = 1'b1; m_frames = 0;
                end else if (edges[5]) begin
                    m_mode = 0; m_run = 1'b1; m_speed = 2; m_frames = 0;
                end else if (edges != 0) begin
                    m_frames = 0;
                    if (edges[1] != edges[0]) m_cursor = (m_cursor + (edges[1] ? 1 : 2)) % 3;
                end else if (frame) begin
                    m_frames++;
                    if (m_frames == 600) begin m_mode = 0; m_run = 1'b1; m_speed = 2; m_frames = 0; end
                end
            end
            2: begin
                if (edges[5]) begin
                    m_mode = 1; m_frames = 0;
                end else if (frame) begin
                    m_frames++;
                    if (m_frames == 32) begin m_mode = 3; m_run = 1'b1; m_speed = 1; m_frames = 0; end
                end
            end
            3: if (frame) begin
                m_frames++;
                m_speed = (1 + m_frames / 8 > 8) ? 8 : 1 + m_frames / 8;
                if (m_frames == 56 + 60) begin m_start = 1'b1; m_mode = 4; end
            end
            default: begin m_run = 1'b1; m_speed = 8; end
        endcase
    endtask

    function automatic logic [23:0] dut_vec();
        return {o_run, o_run_speed, o_jump, o_cursor, o_state, o_start};
    endfunction

    function automatic logic [23:0] exp_vec();
        return {m_run, 16'(m_speed), m_jump, 2'(m_cursor), 3'(m_mode), m_start};
    endfunction

    task automatic step(input bit rst, input bit frame, input logic [5:0] key);
        @(negedge clk);
        rst_n = rst; i_frame = frame; i_key = key;
        @(posedge clk);
        model_update(rst, frame, key);
        #1;
    endtask

    task automatic press(input logic [5:0] key);
        step(1'b1, 1'b0, key);
        step(1'b1, 1'b0, 6'h00);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 6'h00);
        step(1'b0, 1'b0, 6'h00);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 6'h13);
        step(1'b0, 1'b0, 6'h13);
        vectors++;
        if (dut_vec() !== 24'({1'b1, 16'd2, 1'b0, 2'd0, 3'd0, 1'b0})) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec(), {1'b1, 16'd2, 1'b0, 2'd0, 3'd0, 1'b0});
        end
        step(1'b1, 1'b0, 6'h13);
        vectors++;
        if (o_state !== 3'd0) begin
            miscompares++;
            $display("FAIL held_key_release: got state %0d expected 0", o_state);
        end
        step(1'b1, 1'b0, 6'h00);
    endtask

    task automatic test_attract_jump();
        int jumps;
        jumps = 0;
        do_reset();
        for (int i = 0; i < 96; i++) begin
            step(1'b1, 1'b1, 6'h00);
            if (o_jump === 1'b1) jumps++;
            if (i == 95) begin
                vectors++;
                if (o_jump !== 1'b1) begin
                    miscompares++;
                    $display("FAIL attract_jump_timing: got %b expected 1", o_jump);
                end
            end
            step(1'b1, 1'b0, 6'h00);
            if (o_jump === 1'b1) jumps++;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL attract_model: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (jumps != 1 || o_run !== 1'b1 || o_run_speed !== 16'd2) begin
            miscompares++;
            $display("FAIL attract_jump_count: got jumps=%0d run=%b speed=%0d expected 1/1/2", jumps, o_run, o_run_speed);
        end
    endtask

    task automatic test_select_cursor();
        logic [5:0] keys [5] = '{6'h02, 6'h02, 6'h02, 6'h02, 6'h01};
        int         want [5] = '{0, 1, 2, 0, 2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            press(keys[i]);
            vectors++;
            if (o_cursor !== 2'(want[i]) || o_state !== 3'd1) begin
                miscompares++;
                $display("FAIL cursor_step%0d: got cursor=%0d state=%0d expected %0d/1", i, o_cursor, o_state, want[i]);
            end
        end
    endtask

    task automatic test_idle_timeout();
        do_reset();
        press(6'h02);
        press(6'h02);
        repeat (599) step(1'b1, 1'b1, 6'h00);
        vectors++;
        if (o_state !== 3'd1) begin
            miscompares++;
            $display("FAIL idle_599: got state %0d expected 1", o_state);
        end
        press(6'h04);
        repeat (599) step(1'b1, 1'b1, 6'h00);
        vectors++;
        if (o_state !== 3'd1) begin
            miscompares++;
            $display("FAIL idle_restart: got state %0d expected 1", o_state);
        end
        step(1'b1, 1'b1, 6'h00);
        vectors++;
        if (o_state !== 3'd0 || o_cursor !== 2'd1 || o_run !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_timeout: got state=%0d cursor=%0d run=%b expected 0/1/1", o_state, o_cursor, o_run);
        end
    endtask

    task automatic test_launch();
        int starts;
        starts = 0;
        do_reset();
        press(6'h02);
        press(6'h02);
        step(1'b1, 1'b0, 6'h10);
        vectors++;
        if (o_jump !== 1'b1 || o_state !== 3'd2 || o_cursor !== 2'd1) begin
            miscompares++;
            $display("FAIL confirm_entry: got jump=%b state=%0d cursor=%0d expected 1/2/1", o_jump, o_state, o_cursor);
        end
        step(1'b1, 1'b0, 6'h00);
        repeat (31) step(1'b1, 1'b1, 6'h00);
        vectors++;
        if (o_state !== 3'd2 || o_run !== 1'b0) begin
            miscompares++;
            $display("FAIL confirm_hold: got state=%0d run=%b expected 2/0", o_state, o_run);
        end
        step(1'b1, 1'b1, 6'h00);
        vectors++;
        if (o_state !== 3'd3 || o_run_speed !== 16'd1 || o_run !== 1'b1) begin
            miscompares++;
            $display("FAIL launch_entry: got state=%0d speed=%0d run=%b expected 3/1/1", o_state, o_run_speed, o_run);
        end
        repeat (55) step(1'b1, 1'b1, 6'h00);
        vectors++;
        if (o_run_speed !== 16'd7) begin
            miscompares++;
            $display("FAIL ramp_55: got speed %0d expected 7", o_run_speed);
        end
        step(1'b1, 1'b1, 6'h00);
        vectors++;
        if (o_run_speed !== 16'd8) begin
            miscompares++;
            $display("FAIL ramp_56: got speed %0d expected 8", o_run_speed);
        end
        for (int i = 0; i < 59; i++) begin
            step(1'b1, 1'b1, 6'h3f & 6'($urandom));
            if (o_start === 1'b1) starts++;
            vectors++;
            if (o_run_speed !== 16'd8 || o_state !== 3'd3) begin
                miscompares++;
                $display("FAIL launch_hold: got speed=%0d state=%0d expected 8/3", o_run_speed, o_state);
            end
        end
        step(1'b1, 1'b1, 6'h00);
        vectors++;
        if (o_start !== 1'b1 || o_state !== 3'd4 || starts != 0) begin
            miscompares++;
            $display("FAIL start_pulse: got start=%b state=%0d early=%0d expected 1/4/0", o_start, o_state, starts);
        end
        step(1'b1, 1'b1, 6'h00);
        vectors++;
        if (o_start !== 1'b0 || o_state !== 3'd4 || o_run_speed !== 16'd8 || o_run !== 1'b1) begin
            miscompares++;
            $display("FAIL done_hold: got start=%b state=%0d speed=%0d run=%b expected 0/4/8/1", o_start, o_state, o_run_speed, o_run);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press(6'h02);
        press(6'h02);
        press(6'h03);
        vectors++;
        if (o_cursor !== 2'd1) begin
            miscompares++;
            $display("FAIL up_down_same: got cursor %0d expected 1", o_cursor);
        end
        press(6'h30);
        vectors++;
        if (o_state !== 3'd2) begin
            miscompares++;
            $display("FAIL confirm_back_same: got state %0d expected 2", o_state);
        end
        press(6'h20);
        vectors++;
        if (o_state !== 3'd1 || dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL confirm_back_out: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press(6'h02);
        press(6'h10);
        repeat (64) step(1'b1, 1'b1, 6'h00);
        vectors++;
        if (o_run_speed !== 16'd5 || o_state !== 3'd3) begin
            miscompares++;
            $display("FAIL mid_launch_speed: got speed=%0d state=%0d expected 5/3", o_run_speed, o_state);
        end
        step(1'b0, 1'b1, 6'h00);
        vectors++;
        if (o_state !== 3'd0 || o_run_speed !== 16'd2 || o_start !== 1'b0 || o_jump !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got state=%0d speed=%0d start=%b jump=%b expected 0/2/0/0", o_state, o_run_speed, o_start, o_jump);
        end
        step(1'b1, 1'b0, 6'h00);
        vectors++;
        if (o_start !== 1'b0 || o_state !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_reset_trail: got start=%b state=%0d expected 0/0", o_start, o_state);
        end
    endtask

    task automatic test_random();
        logic [5:0] key;
        bit         rst, frame;
        key = '0;
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            rst   = ($urandom_range(0, 799) != 0);
            frame = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) key[$urandom_range(0, 5)] ^= 1'b1;
            if (key[5] && $urandom_range(0, 3) != 0) key[5] = 1'b1;
            step(rst, frame, key);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_attract_jump();
        test_select_cursor();
        test_idle_timeout();
        test_launch();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/menu_sequencer.md
MENU_SEQUENCER -- requirements
Module: menu_sequencer

Interface
REQ-001 Parameters SHALL be: AUTO_JUMP = 96, auto-jump period in ATTRACT (frames); IDLE_TIMEOUT = 600, SELECT inactivity limit (frames); LAUNCH_HOLD = 60, frames at max speed before start; SPD_ATTRACT = 2, ATTRACT run speed (px/frame); SPD_MAX = 8, LAUNCH top speed (px/frame).
REQ-002 Ports SHALL be, in order:
 - i_clk_pix  in  1  pixel clock, the only clock
 - i_rst_n  in  1  synchronous reset, active-low
 - i_frame  in  1  one-cycle pulse, start of each video frame
 - i_key  in  6  raw button levels: [0] up, [1] down, [4] jump/confirm, [5] back
 - o_run  out  1  drives the sprite run enable
 - o_run_speed  out  16  drives the sprite run speed (px/frame)
 - o_jump  out  1  one-cycle jump request to the sprite
 - o_cursor  out  2  selected menu item, 0..2
 - o_state  out  3  current state code
 - o_start  out  1  one-cycle game-start pulse

Function
REQ-003 Key edges SHALL be detected against a 1-cycle-delayed copy of i_key: edge[n] = i_key[n] & ~key_q[n], evaluated on every clock.
REQ-004 States and o_state codes SHALL be ATTRACT=0, SELECT=1, CONFIRM=2, LAUNCH=3, DONE=4; all outputs SHALL be registered.
REQ-005 ATTRACT: o_run=1, o_run_speed=SPD_ATTRACT; the frame counter SHALL count i_frame pulses; when the count reaches AUTO_JUMP-1 on an i_frame, o_jump SHALL pulse next cycle and the count SHALL clear.
REQ-006 ATTRACT -> SELECT on any edge of i_key[0], [1] or [4]; on entry o_run=0, o_cursor=0, frame counter cleared; the triggering edge SHALL NOT move the cursor or confirm.
REQ-007 SELECT, cursor movement:
 - up edge: o_cursor-1, wrapping 0->2
 - down edge: o_cursor+1, wrapping 2->0
 - up and down edges in the same cycle: no movement
 - any key edge clears the inactivity counter
REQ-008 SELECT -> ATTRACT when the inactivity counter reaches IDLE_TIMEOUT-1 on an i_frame, or on a back edge; o_cursor is retained.
REQ-009 SELECT -> CONFIRM on a confirm edge; o_jump SHALL pulse in the same cycle the state changes; confirm takes priority over up/down/back edges in the same cycle.
REQ-010 CONFIRM: o_run=0 for 32 frames; then -> LAUNCH with o_run=1 and o_run_speed=1; a back edge in CONFIRM SHALL return to SELECT.
REQ-011 LAUNCH, speed ramp: o_run_speed SHALL increment by 1 on every 8th i_frame and saturate at SPD_MAX; it SHALL never exceed SPD_MAX.
REQ-012 LAUNCH, start: after LAUNCH_HOLD further frames at SPD_MAX, o_start SHALL pulse for exactly one cycle and the state -> DONE; keys are ignored in LAUNCH.
REQ-013 DONE: o_run=1, o_run_speed=SPD_MAX, o_start=0; held until reset.
REQ-014 i_frame and a key edge in the same cycle: both SHALL be applied, and the key-driven transition wins the state update.
REQ-015 Counters SHALL be 10 bits wide; all widths SHALL be such that no counter wraps before its terminal value.

Reset
REQ-016 While i_rst_n=0 at a clock edge:
 - state=ATTRACT, all counters=0, key_q=i_key
 - o_run=1, o_run_speed=SPD_ATTRACT
 - o_jump=0, o_start=0, o_cursor=0, o_state=0
REQ-017 Reset asserted mid-operation (any state, including during an o_jump or o_start cycle) SHALL take effect on the next edge with no trailing pulses.
REQ-018 A key held high through reset release SHALL NOT produce an edge.

Verification
REQ-019 Reset, then 96 i_frame pulses with no keys -> exactly one o_jump pulse, one cycle after the 96th i_frame; o_run=1, o_run_speed=2.
REQ-020 Down edge in ATTRACT -> SELECT with o_cursor=0; then down, down, down -> o_cursor 1, 2, 0; then an up edge -> o_cursor=2.
REQ-021 In SELECT, no keys for 600 frames -> ATTRACT on the 600th i_frame; a key edge at frame 599 restarts the count.
REQ-022 Confirm edge with o_cursor=1 -> o_jump pulse and o_state=2; after 32 frames o_state=3, o_run_speed=1; o_run_speed reaches 8 after 56 more frames; o_start pulses once, 60 frames after that; o_state=4.
REQ-023 Up and down edges in the same cycle -> o_cursor unchanged; confirm and back edges in the same cycle -> CONFIRM.
REQ-024 Reset asserted in LAUNCH at o_run_speed=5 -> next cycle o_state=0, o_run_speed=2, no o_start pulse.
